gige_lb_regs: RTL

//  Local-bus register slave fed by the Ethernet-to-local-bus bridge (lb_clk = gmii_tx_clk).

---
 rtl/gige_lb_regs_pkg.sv | 23 ++
 rtl/gige_lb_regs_sync_edge.sv | 25 ++
 rtl/gige_lb_regs.sv | 101 ++++++++++
 3 files changed

// File: rtl/gige_lb_regs_pkg.sv
// gige_lb_regs_pkg: register map, ctrl bit indices and status field positions
package gige_lb_regs_pkg;
    typedef logic [31:0] word_t;
    localparam logic [3:0] ADDR_ID      = 4'h0;
    localparam logic [3:0] ADDR_SCRATCH = 4'h1;
    localparam logic [3:0] ADDR_RX_CNT  = 4'h2;
    localparam logic [3:0] ADDR_TX_CNT  = 4'h3;
    localparam logic [3:0] ADDR_STATUS  = 4'h4;
    localparam logic [3:0] ADDR_UPTIME  = 4'h5;
    localparam logic [3:0] ADDR_CTRL    = 4'h6;
    localparam int CTRL_CLR_CNT  = 0;
    localparam int CTRL_CLR_UP   = 1;
    localparam int CTRL_W1C_CPLL = 2;
    localparam int CTRL_W1C_TX   = 3;
    localparam int CTRL_W1C_RX   = 4;
    localparam int ST_AN       = 0;
    localparam int ST_CPLL     = 7;
    localparam int ST_TXPLL    = 8;
    localparam int ST_RXPLL    = 9;
    localparam int ST_LOL_CPLL = 10;
    localparam int ST_LOL_TX   = 11;
    localparam int ST_LOL_RX   = 12;
endpackage

// File: rtl/gige_lb_regs_sync_edge.sv
// lb_sync_edge: 2-FF synchroniser with registered rise/fall pulses
module lb_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic s1, s3;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1   <= 1'b0;
            q    <= 1'b0;
            s3   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            s1   <= d;
            q    <= s1;
            s3   <= q;
            rise <= q & ~s3;
            fall <= ~q & s3;
        end
endmodule

// File: rtl/gige_lb_regs.sv
// gige_lb_regs: local-bus register slave with ID, scratch, frame counters, link status,
// uptime and an external read window; reads return after a 2-stage pipeline.
module gige_lb_regs
    import gige_lb_regs_pkg::*;
#(
    parameter int                LB_AW   = 24,
    parameter int                LB_DW   = 32,
    parameter logic [LB_DW-1:0]  ID_WORD = 32'h67696765,
    parameter int                EXT_BIT = LB_AW - 1
) (
    input  logic             lb_clk,
    input  logic             lb_rst_n,
    input  logic             lb_valid,
    input  logic             lb_rnw,
    input  logic [LB_AW-1:0] lb_addr,
    input  logic [LB_DW-1:0] lb_wdata,
    input  logic             lb_renable,
    output logic [LB_DW-1:0] lb_rdata,
    input  logic [LB_DW-1:0] ext_rdata,
    input  logic             rx_mon,
    input  logic             tx_mon,
    input  logic [6:0]       an_status,
    input  logic             cpll_locked,
    input  logic             txpll_locked,
    input  logic             rxpll_locked,
    output logic             lb_led
);
    logic rx_lvl, rx_rise, rx_fall, tx_lvl, tx_rise, tx_fall;
    logic cpll, cpll_rise, cpll_fall, txpll, txpll_rise, txpll_fall, rxpll, rxpll_rise, rxpll_fall;
    logic [6:0] an_m, an_s;
    logic [LB_DW-1:0] scratch, reg_data;
    logic [31:0] rx_cnt, tx_cnt, uptime, status;
    logic lol_cpll, lol_tx, lol_rx;
    logic wr, wr_ctrl, rd_pend, rd_ext;
    logic [3:0] rd_sel;
    logic unused;

    lb_sync_edge u_rx    (.clk(lb_clk), .rst_n(lb_rst_n), .d(rx_mon),       .q(rx_lvl), .rise(rx_rise),    .fall(rx_fall));
    lb_sync_edge u_tx    (.clk(lb_clk), .rst_n(lb_rst_n), .d(tx_mon),       .q(tx_lvl), .rise(tx_rise),    .fall(tx_fall));
    lb_sync_edge u_cpll  (.clk(lb_clk), .rst_n(lb_rst_n), .d(cpll_locked),  .q(cpll),   .rise(cpll_rise),  .fall(cpll_fall));
    lb_sync_edge u_txpll (.clk(lb_clk), .rst_n(lb_rst_n), .d(txpll_locked), .q(txpll),  .rise(txpll_rise), .fall(txpll_fall));
    lb_sync_edge u_rxpll (.clk(lb_clk), .rst_n(lb_rst_n), .d(rxpll_locked), .q(rxpll),  .rise(rxpll_rise), .fall(rxpll_fall));

    assign unused  = ^{lb_renable, lb_addr[EXT_BIT-1:4], rx_lvl, tx_lvl, rx_fall, tx_fall,
                       cpll_rise, txpll_rise, rxpll_rise};
    assign wr      = lb_valid & ~lb_rnw & ~lb_addr[EXT_BIT];
    assign wr_ctrl = wr & (lb_addr[3:0] == ADDR_CTRL);
    assign status  = {19'b0, lol_rx, lol_tx, lol_cpll, rxpll, txpll, cpll, an_s};

    // Clear beats a coincident increment; a coincident lock loss beats W1C.
    always_ff @(posedge lb_clk or negedge lb_rst_n)
        if (!lb_rst_n) begin
            an_m     <= '0;
            an_s     <= '0;
            scratch  <= '0;
            rx_cnt   <= '0;
            tx_cnt   <= '0;
            uptime   <= '0;
            lol_cpll <= 1'b0;
            lol_tx   <= 1'b0;
            lol_rx   <= 1'b0;
        end else begin
            an_m     <= an_status;
            an_s     <= an_m;
            if (wr && lb_addr[3:0] == ADDR_SCRATCH) scratch <= lb_wdata;
            rx_cnt   <= wr_ctrl && lb_wdata[CTRL_CLR_CNT] ? '0 : rx_cnt + 32'(rx_rise);
            tx_cnt   <= wr_ctrl && lb_wdata[CTRL_CLR_CNT] ? '0 : tx_cnt + 32'(tx_rise);
            uptime   <= wr_ctrl && lb_wdata[CTRL_CLR_UP] ? '0 : uptime + 32'd1;
            lol_cpll <= cpll_fall  | (lol_cpll & ~(wr_ctrl & lb_wdata[CTRL_W1C_CPLL]));
            lol_tx   <= txpll_fall | (lol_tx   & ~(wr_ctrl & lb_wdata[CTRL_W1C_TX]));
            lol_rx   <= rxpll_fall | (lol_rx   & ~(wr_ctrl & lb_wdata[CTRL_W1C_RX]));
        end

    always_comb begin
        reg_data = '0;
        case (rd_sel)
            ADDR_ID:      reg_data = ID_WORD;
            ADDR_SCRATCH: reg_data = scratch;
            ADDR_RX_CNT:  reg_data = LB_DW'(rx_cnt);
            ADDR_TX_CNT:  reg_data = LB_DW'(tx_cnt);
            ADDR_STATUS:  reg_data = LB_DW'(status);
            ADDR_UPTIME:  reg_data = LB_DW'(uptime);
            default:      reg_data = '0;
        endcase
    end

    always_ff @(posedge lb_clk or negedge lb_rst_n)
        if (!lb_rst_n) begin
            rd_pend  <= 1'b0;
            rd_ext   <= 1'b0;
            rd_sel   <= '0;
            lb_rdata <= '0;
            lb_led   <= 1'b0;
        end else begin
            rd_pend  <= lb_valid & lb_rnw;
            rd_ext   <= lb_addr[EXT_BIT];
            rd_sel   <= lb_addr[3:0];
            lb_led   <= rd_pend;
            if (rd_pend) lb_rdata <= rd_ext ? ext_rdata : reg_data;
        end
endmodule
